// File: rtl/uart_word_loader_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_word_loader_tx
//  Purpose  : UART boot-stream serializer. Buffers DATA_WIDTH-bit words in a
//             small FIFO and sends each one as DATA_WIDTH/8 UART frames, least
//             significant byte first and LSB-first bits. An optional parity
//             bit and 1 or 2 stop bits follow each byte. After the word marked
//             "last", the line idles for GAP_BITS bit-times and then boot_en_o
//             rises and stays high until reset.
//  Ports    : clk_i        system clock
//             rst_ni       asynchronous active-low reset
//             word_i       instruction word to send
//             word_valid_i word_i / word_last_i valid
//             word_last_i  final word of the image
//             word_ready_o FIFO can accept a word
//             uart_tx_o    serial line, idle high
//             busy_o       transmitting, in gap, or FIFO non-empty
//             boot_en_o    sticky: image fully sent
//             words_sent_o count of completely transmitted words
//  Revision : 1.0 - initial release
// ============================================================================
module uart_word_loader_tx #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  word_valid_i,
    input  logic                  word_last_i,
    output logic                  word_ready_o,
    output logic                  uart_tx_o,
    output logic                  busy_o,
    output logic                  boot_en_o,
    output logic [31:0]           words_sent_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW    = $clog2((GAP_BITS > 8) ? GAP_BITS : 8) + 1;
    localparam int YW    = $clog2(BYTES) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // FIFO storage: {last, word}
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [AW:0]           count_nxt;
    logic [DATA_WIDTH:0]   head;

    state_t                state;
    logic [CW-1:0]         cyc;
    logic [BW-1:0]         bit_idx;
    logic [YW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  last_word;
    logic                  par;

    logic bit_end;
    logic push;
    logic pop;
    logic to_done;
    logic flush;
    logic stop_end;
    logic word_end;
    logic to_idle;
    logic ready_nxt;
    logic busy_nxt;

    assign head     = mem[rd_ptr];
    assign bit_end  = (cyc == CW'(CLKS_PER_BIT - 1));
    assign push     = word_valid_i && word_ready_o;
    assign pop      = (state == S_IDLE) && (count != '0);
    assign to_done  = (state == S_GAP) && bit_end && (bit_idx == BW'(GAP_BITS - 1));
    // Anything still queued once the image is complete is dropped.
    assign flush    = to_done || (state == S_DONE);
    assign stop_end = (state == S_STOP) && bit_end && (bit_idx == BW'(STOP_BITS - 1));
    assign word_end = stop_end && (byte_idx == YW'(BYTES - 1));
    assign to_idle  = word_end && !last_word;

    assign count_nxt = flush ? '0 : (count + (AW+1)'(push) - (AW+1)'(pop));

    // Ready and busy are registered, so they are computed from next-cycle state.
    assign ready_nxt = (count_nxt != (AW+1)'(FIFO_DEPTH)) && !flush;
    assign busy_nxt  = (count_nxt != '0) ||
                       ((state == S_IDLE) ? pop : !(flush || to_idle));

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {word_last_i, word_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            word_ready_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            word_ready_o <= ready_nxt;
            busy_o       <= busy_nxt;
            count        <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            cyc          <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            last_word    <= 1'b0;
            par          <= 1'b0;
            uart_tx_o    <= 1'b1;
            boot_en_o    <= 1'b0;
            words_sent_o <= '0;
        end else begin
            // Bit-time counter restarts whenever a bit period completes.
            cyc <= bit_end ? '0 : cyc + 1'b1;
            case (state)
                S_IDLE: begin
                    cyc <= '0;
                    if (count != '0) begin
                        shreg     <= head[DATA_WIDTH-1:0];
                        last_word <= head[DATA_WIDTH];
                        byte_idx  <= '0;
                        bit_idx   <= '0;
                        par       <= (PARITY_ODD != 0);
                        uart_tx_o <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state     <= S_DATA;
                        bit_idx   <= '0;
                        uart_tx_o <= shreg[0];
                        par       <= par ^ shreg[0];
                        shreg     <= shreg >> 1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == BW'(7)) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state     <= S_PARITY;
                                uart_tx_o <= par;
                            end else begin
                                state     <= S_STOP;
                                uart_tx_o <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            uart_tx_o <= shreg[0];
                            par       <= par ^ shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state     <= S_STOP;
                        bit_idx   <= '0;
                        uart_tx_o <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_end) begin
                            bit_idx  <= '0;
                            byte_idx <= byte_idx + 1'b1;
                            if (word_end) begin
                                words_sent_o <= words_sent_o + 32'd1;
                                state        <= last_word ? S_GAP : S_IDLE;
                            end else begin
                                state     <= S_START;
                                uart_tx_o <= 1'b0;
                                par       <= (PARITY_ODD != 0);
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (bit_end) begin
                        if (to_done) begin
                            state     <= S_DONE;
                            boot_en_o <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cyc       <= '0;
                    boot_en_o <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    uart_tx_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_loader_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_word_loader_tx
//  Purpose  : Self-checking bench for uart_word_loader_tx. A UART receiver
//             model decodes the main instance's line and compares each byte
//             against a scoreboard queue filled when words are pushed. Two
//             extra instances exercise parity and stop-bit options.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_loader_tx;

    localparam int CPB = 4;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic [31:0] word = '0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        ready, tx, busy, boot;
    logic [31:0] sent;

    // parity instances share one input port
    logic [31:0] pword = '0;
    logic        pvalid = 1'b0;
    logic        plast = 1'b0;
    logic        p_ready, p_tx, p_busy, p_boot;
    logic [31:0] p_sent;
    logic        q_ready, q_tx, q_busy, q_boot;
    logic [31:0] q_sent;

    uart_word_loader_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) m (
        .clk_i(clk), .rst_ni(rst_n), .word_i(word), .word_valid_i(valid),
        .word_last_i(last), .word_ready_o(ready), .uart_tx_o(tx),
        .busy_o(busy), .boot_en_o(boot), .words_sent_o(sent));

    uart_word_loader_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP), .PARITY_EN(1),
                          .PARITY_ODD(0), .STOP_BITS(2)) p (
        .clk_i(clk), .rst_ni(rst_n), .word_i(pword), .word_valid_i(pvalid),
        .word_last_i(plast), .word_ready_o(p_ready), .uart_tx_o(p_tx),
        .busy_o(p_busy), .boot_en_o(p_boot), .words_sent_o(p_sent));

    uart_word_loader_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP), .PARITY_EN(1),
                          .PARITY_ODD(1), .STOP_BITS(1)) q (
        .clk_i(clk), .rst_ni(rst_n), .word_i(pword), .word_valid_i(pvalid),
        .word_last_i(plast), .word_ready_o(q_ready), .uart_tx_o(q_tx),
        .busy_o(q_busy), .boot_en_o(q_boot), .words_sent_o(q_sent));

    int       tests = 0;
    int       fails = 0;
    logic [7:0] sb[$];
    bit       rx_en = 1'b1;
    bit       rx_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = 1'b0; pvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_boot", boot, 0);
        check("rst_busy", busy, 0);
        check("rst_sent", sent, 0);
        check("rst_ready", ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", ready, 0);
        wait_cycles(1);
        check("ready_after_edge", ready, 1);
    endtask

    task automatic push_word(input logic [31:0] w, input logic l, input bit exp_out,
                             output bit saw_bp);
        int t;
        t = 0;
        saw_bp = 1'b0;
        @(negedge clk);
        word = w; last = l; valid = 1'b1;
        while (ready !== 1'b1 && t < 1000) begin
            saw_bp = 1'b1;
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        if (exp_out) for (int i = 0; i < 4; i++) sb.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_boot(input int limit);
        int t;
        t = 0;
        while (boot !== 1'b1 && t < limit) begin
            wait_cycles(1);
            t++;
        end
        check("boot_en_timeout", boot, 1);
    endtask

    // UART receiver model: samples mid-bit, pops the scoreboard per byte.
    always begin
        logic [7:0] b;
        logic       st;
        logic       sp;
        @(negedge clk);
        if (rst_n && rx_en && tx === 1'b0) begin
            rx_busy = 1'b1;
            repeat (2) @(negedge clk);
            st = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            sp = tx;
            if (rx_en) begin
                check("rx_start", st, 0);
                check("rx_stop", sp, 1);
                if (sb.size() == 0) begin
                    check("rx_unexpected_byte", 0, 1);
                end else begin
                    check("rx_byte", b, sb.pop_front());
                end
            end
            rx_busy = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         bp;
        bit         any_bp;
        logic [9:0] fb;
        int         t;

        // ---- 1: single last word, exact frame timing and boot_en delay ----
        do_reset();
        push_word(32'h0020_0113, 1'b1, 1'b1, bp);
        fb = {1'b1, 8'h13, 1'b0};
        wait_cycles(1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("frame_bit%0d_first", k), tx, fb[k]);
            wait_cycles(CPB - 1);
            check($sformatf("frame_bit%0d_last", k), tx, fb[k]);
            wait_cycles(1);
        end
        check("busy_mid_word", busy, 1);
        wait_cycles(119);
        check("sent_before_word_end", sent, 0);
        wait_cycles(1);
        check("sent_after_word_end", sent, 1);
        wait_cycles(GAP * CPB - 1);
        check("boot_before_gap_end", boot, 0);
        check("tx_idle_in_gap", tx, 1);
        wait_cycles(1);
        check("boot_at_gap_end", boot, 1);
        wait_cycles(1);
        check("busy_done", busy, 0);
        check("ready_done", ready, 0);
        check("sb_empty_t1", sb.size(), 0);

        // ---- 2: parity and stop bits on byte 0x13 ----
        do_reset();
        @(negedge clk);
        pword = 32'h0000_0013; plast = 1'b1; pvalid = 1'b1;
        @(posedge clk);
        #1;
        pvalid = 1'b0;
        wait_cycles(3 + 4 * 9);
        check("even_parity", p_tx, ^8'h13);
        check("odd_parity", q_tx, ~^8'h13);
        wait_cycles(4);
        check("p_stop1", p_tx, 1);
        check("q_stop1", q_tx, 1);
        wait_cycles(4);
        check("p_stop2", p_tx, 1);
        check("q_next_start", q_tx, 0);
        wait_cycles(4);
        check("p_next_start", p_tx, 0);

        // ---- 3: six words through a 4-deep FIFO ----
        do_reset();
        any_bp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_word(32'hA000_0000 + 32'h0101_0101 * i + 32'h37, (i == 5), 1'b1, bp);
            any_bp = any_bp | bp;
        end
        check("backpressure_seen", any_bp, 1);
        wait_boot(3000);
        check("sent_six", sent, 6);
        check("sb_empty_t3", sb.size(), 0);

        // ---- 4: reset mid-DATA of word 2 ----
        do_reset();
        push_word(32'h1234_5678, 1'b0, 1'b1, bp);
        push_word(32'h0000_00A5, 1'b0, 1'b1, bp);
        t = 0;
        while (sent !== 32'd1 && t < 500) begin wait_cycles(1); t++; end
        check("word1_done", sent, 1);
        wait_cycles(10);
        check("pre_reset_data_bit", tx, 0);
        rx_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_tx_high", tx, 1);
        check("async_sent_zero", sent, 0);
        repeat (3) @(posedge clk);
        sb.delete();
        t = 0;
        while (rx_busy && t < 100) begin @(posedge clk); t++; end
        check("rx_quiesce", rx_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_en = 1'b1;
        push_word(32'hCAFE_F00D, 1'b1, 1'b1, bp);
        wait_boot(500);
        check("sent_after_reset", sent, 1);
        check("sb_empty_t4", sb.size(), 0);

        // ---- 5: words after the last word are discarded ----
        do_reset();
        push_word(32'h0BAD_BEEF, 1'b1, 1'b1, bp);
        push_word(32'h5555_AAAA, 1'b0, 1'b0, bp);
        wait_boot(500);
        wait_cycles(2);
        check("sent_only_first", sent, 1);
        check("ready_low_done", ready, 0);
        check("busy_low_done", busy, 0);
        wait_cycles(50);
        check("ready_still_low", ready, 0);
        check("tx_idle_done", tx, 1);
        check("sent_still_one", sent, 1);
        check("sb_empty_t5", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
